// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
// ---------------
// Round-robin arbiter that shares one resource among N requesters using a
// one-hot rotating token ring. Each cycle it either idles or holds one grant.
// A grant ends on done, when the owner drops its request, or when the hold
// timer reaches TMAX. After each release the token moves to the position just
// past the last winner, so every requester is eventually served.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rstn         in   1  synchronous reset, active-high
//   en           in   1  arbitration enable (gates new grants only)
//   req          in   N  request vector, bit i = requester i
//   done         in   1  current owner finished, releases the grant
//   grant        out  N  one-hot grant, zero when idle
//   grant_valid  out  1  OR of grant
//   token        out  N  one-hot ring pointer (highest priority next time)
//   timeout      out  1  one-cycle pulse after a forced release at TMAX
module ring_rr_arbiter #(
  parameter int N    = 4,
  parameter int TMAX = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [N-1:0] token,
  output logic         timeout
);

  localparam int CW = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMAX - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   token_q, token_d;
  logic           gv_q;
  logic           timeout_q, timeout_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [2*N-1:0] req_dbl_s;
  logic [2*N-1:0] dbl_pick_s;
  logic [N-1:0]   winner_s;
  logic           owner_req_s;
  logic [N-1:0]   token_next_s;

  // Winner search: in the doubled request vector, subtracting the one-hot
  // token clears every bit below the token and the borrow stops at the first
  // set request at or above it; folding both halves handles the wrap.
  always_comb begin
    req_dbl_s  = {req, req};
    dbl_pick_s = req_dbl_s & ~(req_dbl_s - {{N{1'b0}}, token_q});
    winner_s   = dbl_pick_s[N-1:0] | dbl_pick_s[2*N-1:N];
  end

  // Owner status and the token position that follows the current owner.
  always_comb begin
    owner_req_s  = |(req & grant_q);
    token_next_s = {grant_q[N-2:0], grant_q[N-1]};
  end

  // Next-state logic: arbitration in IDLE, release handling in GRANT.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    token_d   = token_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && (|req)) begin
          grant_d = winner_s;
          cnt_d   = CNT_ZERO;
          state_d = ST_GRANT;
        end else begin
          grant_d = grant_q;
        end
      end
      ST_GRANT: begin
        // done beats request drop, which beats the timer; only the timer
        // path raises the timeout pulse.
        if (done || !owner_req_s || (cnt_q == CNT_LAST)) begin
          grant_d   = '0;
          token_d   = token_next_s;
          cnt_d     = CNT_ZERO;
          state_d   = ST_IDLE;
          timeout_d = !done && owner_req_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        token_d = {{(N-1){1'b0}}, 1'b1};
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      token_q   <= {{(N-1){1'b0}}, 1'b1};
      gv_q      <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      token_q   <= token_d;
      gv_q      <= |grant_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign token       = token_q;
  assign timeout     = timeout_q;

endmodule
